dsp_mac_pipe: RTL and testbench

Parametrised successor of the team's fixed 18x18/48-bit DSP slice. It contains an optional pre-adder/subtracter, a multiplier, and a post-adder/accumulator, with configurable widths, signedness and input pipeline depth. Unlike the fixed slice, it carries a valid bit through the pipeline, so bubbles never corrupt the accumulator. It also has a frame-restart input and a registered overflow flag. It sits in the same datapath as the fixed slice and cascades via pcin/pcout.

---
 rtl/dsp_mac_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsp_mac_pipe: parametrised pre-add / multiply / accumulate slice with a  |
// | valid-qualified pipeline. Optional saturation via DSP_MAC_SAT_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48,
  parameter int SIGNED  = 0,
  parameter int IN_REGS = 1,
  parameter int MREG    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic [B_WIDTH-1:0] d,
  input  logic [P_WIDTH-1:0] c,
  input  logic [P_WIDTH-1:0] pcin,
  input  logic               carry_in,
  input  logic [4:0]         opmode,
  output logic [P_WIDTH-1:0] p,
  output logic [P_WIDTH-1:0] pcout,
  output logic [B_WIDTH-1:0] bcout,
  output logic               out_valid,
  output logic               ovf,
  output logic               sat
);

  localparam int   c_M_WIDTH  = A_WIDTH + B_WIDTH + 1;
  localparam int   c_IN_WIDTH = 8 + P_WIDTH + 2 * B_WIDTH + A_WIDTH;
  localparam int   c_MB_WIDTH = 6 + 2 * P_WIDTH;
  localparam logic c_SIGNED   = (SIGNED != 0);

  if (P_WIDTH < c_M_WIDTH) begin : g_bad_p_width
    $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
  end
  if (IN_REGS < 0 || IN_REGS > 2) begin : g_bad_in_regs
    $error("dsp_mac_pipe: IN_REGS must be 0..2");
  end
  if (MREG < 0 || MREG > 1) begin : g_bad_mreg
    $error("dsp_mac_pipe: MREG must be 0 or 1");
  end

  // Input stage: every control travels with its operands so they stay aligned.
  logic [c_IN_WIDTH-1:0] w_in_bus;
  logic [c_IN_WIDTH-1:0] w_s1_bus;

  assign w_in_bus = {in_valid, in_first, carry_in, opmode, c, d, b, a};

  if (IN_REGS == 0) begin : g_in_none
    assign w_s1_bus = w_in_bus;
  end else begin : g_in_regs
    logic [c_IN_WIDTH-1:0] r_stage [IN_REGS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < IN_REGS; i++) r_stage[i] <= '0;
      end else if (ce) begin
        r_stage[0] <= w_in_bus;
        for (int i = 1; i < IN_REGS; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign w_s1_bus = r_stage[IN_REGS-1];
  end

  logic               w_s1_valid;
  logic               w_s1_first;
  logic               w_s1_carry;
  logic [4:0]         w_s1_opmode;
  logic [P_WIDTH-1:0] w_s1_c;
  logic [B_WIDTH-1:0] w_s1_d;
  logic [B_WIDTH-1:0] w_s1_b;
  logic [A_WIDTH-1:0] w_s1_a;

  assign {w_s1_valid, w_s1_first, w_s1_carry, w_s1_opmode,
          w_s1_c, w_s1_d, w_s1_b, w_s1_a} = w_s1_bus;

  assign bcout = w_s1_b;

  // Pre-adder in B_WIDTH+1 bits; unsigned underflow wraps naturally.
  logic [B_WIDTH:0] w_b_ext;
  logic [B_WIDTH:0] w_d_ext;
  logic [B_WIDTH:0] w_bpre;

  assign w_b_ext = {c_SIGNED & w_s1_b[B_WIDTH-1], w_s1_b};
  assign w_d_ext = {c_SIGNED & w_s1_d[B_WIDTH-1], w_s1_d};

  always_comb begin
    w_bpre = w_b_ext;
    if (w_s1_opmode[0]) begin
      w_bpre = w_s1_opmode[1] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
    end
  end

  // Modular product of the extended operands equals the exact product here.
  logic [c_M_WIDTH-1:0] w_a_mx;
  logic [c_M_WIDTH-1:0] w_b_mx;
  logic [c_M_WIDTH-1:0] w_prod;
  logic [P_WIDTH-1:0]   w_m_ext;

  assign w_a_mx = {{(B_WIDTH + 1){c_SIGNED & w_s1_a[A_WIDTH-1]}}, w_s1_a};
  assign w_b_mx = {{A_WIDTH{c_SIGNED & w_bpre[B_WIDTH]}}, w_bpre};
  assign w_prod = w_a_mx * w_b_mx;

  if (P_WIDTH > c_M_WIDTH) begin : g_m_extend
    assign w_m_ext = {{(P_WIDTH - c_M_WIDTH){c_SIGNED & w_prod[c_M_WIDTH-1]}}, w_prod};
  end else begin : g_m_exact
    assign w_m_ext = w_prod[P_WIDTH-1:0];
  end

  // Multiplier stage carries only the post-adder controls (opmode[4:2]).
  logic [c_MB_WIDTH-1:0] w_m_bus_in;
  logic [c_MB_WIDTH-1:0] w_m_bus;

  assign w_m_bus_in = {w_s1_valid, w_s1_first, w_s1_carry, w_s1_opmode[4:2], w_s1_c, w_m_ext};

  if (MREG != 0) begin : g_mreg
    logic [c_MB_WIDTH-1:0] r_m_bus;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_m_bus <= '0;
      end else if (ce) begin
        r_m_bus <= w_m_bus_in;
      end
    end

    assign w_m_bus = r_m_bus;
  end else begin : g_no_mreg
    assign w_m_bus = w_m_bus_in;
  end

  logic               w_p_valid;
  logic               w_p_first;
  logic               w_p_carry;
  logic [2:0]         w_p_op;
  logic [P_WIDTH-1:0] w_p_c;
  logic [P_WIDTH-1:0] w_p_m;

  assign {w_p_valid, w_p_first, w_p_carry, w_p_op, w_p_c, w_p_m} = w_m_bus;

  logic [P_WIDTH-1:0] r_p;
  logic               r_ovf;
  logic               r_sat;
  logic               r_out_valid;

  logic [P_WIDTH-1:0] w_z;

  always_comb begin
    w_z = '0;
    if (!w_p_first) begin
      case (w_p_op[1:0])
        2'b01:   w_z = r_p;
        2'b10:   w_z = w_p_c;
        2'b11:   w_z = pcin;
        default: w_z = '0;
      endcase
    end
  end

  // One extra bit holds the true result: carry/borrow when unsigned, sign when signed.
  logic [P_WIDTH:0] w_z_x;
  logic [P_WIDTH:0] w_m_x;
  logic [P_WIDTH:0] w_cin_x;
  logic [P_WIDTH:0] w_full;
  logic             w_ovf;

  assign w_z_x   = {c_SIGNED & w_z[P_WIDTH-1], w_z};
  assign w_m_x   = {c_SIGNED & w_p_m[P_WIDTH-1], w_p_m};
  assign w_cin_x = {{P_WIDTH{1'b0}}, w_p_carry};
  assign w_full  = w_p_op[2] ? (w_z_x - w_m_x - w_cin_x) : (w_z_x + w_m_x + w_cin_x);
  assign w_ovf   = c_SIGNED ? (w_full[P_WIDTH] ^ w_full[P_WIDTH-1]) : w_full[P_WIDTH];

  logic [P_WIDTH-1:0] w_p_next;
  logic               w_sat;

`ifdef DSP_MAC_SAT_EN
  always_comb begin
    w_p_next = w_full[P_WIDTH-1:0];
    w_sat    = 1'b0;
    if (w_ovf) begin
      w_sat = 1'b1;
      if (c_SIGNED) begin
        w_p_next = w_full[P_WIDTH] ? {1'b1, {(P_WIDTH - 1){1'b0}}}
                                   : {1'b0, {(P_WIDTH - 1){1'b1}}};
      end else begin
        w_p_next = w_p_op[2] ? '0 : '1;
      end
    end
  end
`else
  assign w_p_next = w_full[P_WIDTH-1:0];
  assign w_sat    = 1'b0;
`endif

  // Bubbles shift through out_valid but never touch p/ovf/sat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p         <= '0;
      r_ovf       <= 1'b0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_p_valid;
      if (w_p_valid) begin
        r_p   <= w_p_next;
        r_ovf <= w_ovf;
        r_sat <= w_sat;
      end
    end
  end

  assign p         = r_p;
  assign pcout     = r_p;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dsp_mac_pipe: directed bench for dsp_mac_pipe, unsigned and signed    |
// | instances driven in parallel. Revision: 1.0                              |
// +--------------------------------------------------------------------------+
module tb_dsp_mac_pipe;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        ce       = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        carry_in = 1'b0;
  logic [17:0] a        = '0;
  logic [17:0] b        = '0;
  logic [17:0] d        = '0;
  logic [47:0] c        = '0;
  logic [47:0] pcin     = '0;
  logic [4:0]  opmode   = '0;

  logic [47:0] u_p, u_pcout, s_p, s_pcout;
  logic [17:0] u_bcout, s_bcout;
  logic        u_ov, u_ovf, u_sat, s_ov, s_ovf, s_sat;

  int checks = 0;
  int errors = 0;

  dsp_mac_pipe u_dut_u (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .carry_in(carry_in), .opmode(opmode),
    .p(u_p), .pcout(u_pcout), .bcout(u_bcout), .out_valid(u_ov), .ovf(u_ovf), .sat(u_sat)
  );

  dsp_mac_pipe #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .carry_in(carry_in), .opmode(opmode),
    .p(s_p), .pcout(s_pcout), .bcout(s_bcout), .out_valid(s_ov), .ovf(s_ovf), .sat(s_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic        t2_v [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        t2_f [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [17:0] t2_b [7] = '{18'd1, 18'd2, 18'd0, 18'd3, 18'd4, 18'd0, 18'd0};
  logic [47:0] t2_p [5] = '{48'd2, 48'd6, 48'd6, 48'd12, 48'd20};
  logic        t2_o [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state
    tick();
    tick();
    chkp("rst_p", u_p, 48'd0);
    chk1("rst_ov", u_ov, 1'b0);
    chk1("rst_ovf", u_ovf, 1'b0);
    chk1("rst_sat", u_sat, 1'b0);
    chkp("rst_bcout", {30'd0, u_bcout}, 48'd0);
    chkp("rst_s_p", s_p, 48'd0);
    rst = 1'b0;

    // Single product, latency 3
    a = 18'd3; b = 18'd5; opmode = 5'b00000; in_first = 1'b1;
    fire();
    chkp("t1_bcout", {30'd0, u_bcout}, 48'd5);
    chkp("t1_s_bcout", {30'd0, s_bcout}, 48'd5);
    chk1("t1_ov_e1", u_ov, 1'b0);
    tick();
    chk1("t1_ov_e2", u_ov, 1'b0);
    tick();
    chk1("t1_ov_e3", u_ov, 1'b1);
    chkp("t1_p", u_p, 48'd15);
    chkp("t1_pcout", u_pcout, 48'd15);
    chk1("t1_ovf", u_ovf, 1'b0);
    chkp("t1_s_p", s_p, 48'd15);
    chkp("t1_s_pcout", s_pcout, 48'd15);
    chk1("t1_s_ov", s_ov, 1'b1);
    tick();
    chk1("t1_ov_e4", u_ov, 1'b0);
    chkp("t1_p_hold", u_p, 48'd15);

    // Back-to-back accumulation with a bubble
    opmode = 5'b00100; a = 18'd2;
    for (int i = 0; i < 7; i++) begin
      in_valid = t2_v[i]; in_first = t2_f[i]; b = t2_b[i];
      tick();
      if (i >= 2) begin
        chkp("t2_p", u_p, t2_p[i-2]);
        chk1("t2_ov", u_ov, t2_o[i-2]);
      end
    end
    in_valid = 1'b0;

    // Pre-subtract D-B
    opmode = 5'b00011; a = 18'd4; d = 18'd10; b = 18'd3; in_first = 1'b1;
    fire(); tick(); tick();
    chkp("t3_u_p", u_p, 48'd28);
    chkp("t3_s_p", s_p, 48'd28);
    d = 18'd3; b = 18'd10;
    fire(); tick(); tick();
    chkp("t3_s_neg", s_p, 48'hFFFF_FFFF_FFE4);
    chk1("t3_s_ovf", s_ovf, 1'b0);
    chkp("t3_u_wrap", u_p, 48'h1F_FFE4);
    chk1("t3_u_ovf", u_ovf, 1'b0);

    // Clock-enable freeze while a sample is mid-pipe
    opmode = 5'b00000; a = 18'd3; b = 18'd5; d = 18'd0; in_first = 1'b1;
    fire(); tick();
    ce = 1'b0;
    tick();
    chk1("t4_ov_f1", u_ov, 1'b0);
    chkp("t4_p_f1", u_p, 48'h1F_FFE4);
    tick();
    chk1("t4_ov_f2", u_ov, 1'b0);
    chkp("t4_p_f2", u_p, 48'h1F_FFE4);
    ce = 1'b1;
    tick();
    chk1("t4_ov", u_ov, 1'b1);
    chkp("t4_p", u_p, 48'd15);
    tick();
    chk1("t4_ov_once", u_ov, 1'b0);

    // Asynchronous reset mid-frame
    opmode = 5'b00100; a = 18'd2;
    in_valid = 1'b1; in_first = 1'b1; b = 18'd1; tick();
    in_first = 1'b0; b = 18'd2; tick();
    b = 18'd3; tick();
    chkp("t5_p2", u_p, 48'd2);
    b = 18'd4; tick();
    chkp("t5_p6", u_p, 48'd6);
    in_valid = 1'b0; tick();
    chkp("t5_p12", u_p, 48'd12);
    #2 rst = 1'b1;
    #1;
    chkp("t5_rst_p", u_p, 48'd0);
    chk1("t5_rst_ov", u_ov, 1'b0);
    chkp("t5_rst_s_p", s_p, 48'd0);
    tick();
    rst = 1'b0;
    tick();
    chk1("t5_flush1", u_ov, 1'b0);
    tick();
    chk1("t5_flush2", u_ov, 1'b0);
    chkp("t5_p_zero", u_p, 48'd0);
    b = 18'd5;
    fire(); tick(); tick();
    chkp("t5_restart", u_p, 48'd10);
    chk1("t5_restart_ov", u_ov, 1'b1);

    // Signed positive overflow through Z=C
    opmode = 5'b01000; c = 48'h7FFF_FFFF_FFFF; a = 18'd1; b = 18'd1; in_first = 1'b0;
    fire(); tick(); tick();
    chk1("t6_s_ovf", s_ovf, 1'b1);
`ifdef DSP_MAC_SAT_EN
    chkp("t6_s_p", s_p, 48'h7FFF_FFFF_FFFF);
    chk1("t6_s_sat", s_sat, 1'b1);
`else
    chkp("t6_s_p", s_p, 48'h8000_0000_0000);
    chk1("t6_s_sat", s_sat, 1'b0);
`endif
    chkp("t6_u_p", u_p, 48'h8000_0000_0000);
    chk1("t6_u_ovf", u_ovf, 1'b0);
    chk1("t6_u_sat", u_sat, 1'b0);

    // Post-subtract borrow: 0 - 1
    opmode = 5'b10000; c = 48'd0; in_first = 1'b1;
    fire(); tick(); tick();
    chk1("t7_u_ovf", u_ovf, 1'b1);
`ifdef DSP_MAC_SAT_EN
    chkp("t7_u_p", u_p, 48'd0);
    chk1("t7_u_sat", u_sat, 1'b1);
`else
    chkp("t7_u_p", u_p, 48'hFFFF_FFFF_FFFF);
    chk1("t7_u_sat", u_sat, 1'b0);
`endif
    chkp("t7_s_p", s_p, 48'hFFFF_FFFF_FFFF);
    chk1("t7_s_ovf", s_ovf, 1'b0);
    chk1("t7_s_sat", s_sat, 1'b0);

    // carry_in with Z=C, then Z=PCIN
    opmode = 5'b01000; c = 48'd5; a = 18'd2; b = 18'd3; in_first = 1'b0; carry_in = 1'b1;
    fire();
    carry_in = 1'b0;
    tick(); tick();
    chkp("t8_carry", u_p, 48'd12);
    opmode = 5'b01100; pcin = 48'd100; a = 18'd1; b = 18'd1;
    fire(); tick(); tick();
    chkp("t8_pcin", u_p, 48'd101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
